// File: rtl/m_dram_port_if.sv
// Signal bundle between a user-side requester / MIG app interface and m_dram_port.
// Names keep the port-relative i_/o_ prefixes of the original flat port list.
interface m_dram_port_if;
   logic         i_calib;
   logic         i_valid;
   logic         o_ready;
   logic         i_we;
   logic [27:0]  i_addr;
   logic [31:0]  i_wdata;
   logic         o_rvalid;
   logic [31:0]  o_rdata;
   logic         o_done;
   logic         o_err;
   logic [27:0]  o_app_addr;
   logic [2:0]   o_app_cmd;
   logic         o_app_en;
   logic [127:0] o_app_wdf_data;
   logic         o_app_wdf_wren;
   logic         o_app_wdf_end;
   logic [15:0]  o_app_wdf_mask;
   logic [127:0] i_app_rd_data;
   logic         i_app_rd_data_valid;
   logic         i_app_rdy;
   logic         i_app_wdf_rdy;

   modport slave (
      input  i_calib, i_valid, i_we, i_addr, i_wdata,
             i_app_rd_data, i_app_rd_data_valid, i_app_rdy, i_app_wdf_rdy,
      output o_ready, o_rvalid, o_rdata, o_done, o_err,
             o_app_addr, o_app_cmd, o_app_en, o_app_wdf_data,
             o_app_wdf_wren, o_app_wdf_end, o_app_wdf_mask
   );

   modport master (
      output i_calib, i_valid, i_we, i_addr, i_wdata,
             i_app_rd_data, i_app_rd_data_valid, i_app_rdy, i_app_wdf_rdy,
      input  o_ready, o_rvalid, o_rdata, o_done, o_err,
             o_app_addr, o_app_cmd, o_app_en, o_app_wdf_data,
             o_app_wdf_wren, o_app_wdf_end, o_app_wdf_mask
   );
endinterface

// File: rtl/m_dram_port.sv
// Single-outstanding 32-bit user port onto a 128-bit MIG app interface,
// with lane-masked writes, lane-selected reads and a read-data watchdog.
module m_dram_port #(
   parameter int unsigned TIMEOUT = 1024
) (
   input logic           w_clk,
   input logic           w_rst,
   m_dram_port_if.slave  bus
);

   localparam int unsigned CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   typedef enum logic [2:0] {IDLE, WRITE, READ_CMD, READ_WAIT, RESP} state_t;
   typedef enum logic [1:0] {K_DONE, K_RD, K_ERR} kind_t;

   state_t         state_q, state_d;
   kind_t          kind_q, kind_d;
   logic           en_q, en_d;
   logic           wren_q, wren_d;
   logic [27:0]    addr_q, addr_d;
   logic [2:0]     cmd_q, cmd_d;
   logic [127:0]   wdata_q, wdata_d;
   logic [15:0]    mask_q, mask_d;
   logic [1:0]     lane_q, lane_d;
   logic [31:0]    rdata_q, rdata_d;
   logic [CW-1:0]  cnt_q, cnt_d;

   always_ff @(posedge w_clk or posedge w_rst) begin
      if (w_rst) begin
         state_q <= IDLE;
         kind_q  <= K_DONE;
         en_q    <= 1'b0;
         wren_q  <= 1'b0;
         addr_q  <= '0;
         cmd_q   <= '0;
         wdata_q <= '0;
         mask_q  <= '1;
         lane_q  <= '0;
         rdata_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         kind_q  <= kind_d;
         en_q    <= en_d;
         wren_q  <= wren_d;
         addr_q  <= addr_d;
         cmd_q   <= cmd_d;
         wdata_q <= wdata_d;
         mask_q  <= mask_d;
         lane_q  <= lane_d;
         rdata_q <= rdata_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      kind_d  = kind_q;
      en_d    = en_q;
      wren_d  = wren_q;
      addr_d  = addr_q;
      cmd_d   = cmd_q;
      wdata_d = wdata_q;
      mask_d  = mask_q;
      lane_d  = lane_q;
      rdata_d = rdata_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (bus.i_valid && bus.i_calib) begin
               addr_d = {bus.i_addr[27:3], 3'b000};
               lane_d = bus.i_addr[2:1];
               en_d   = 1'b1;
               if (bus.i_we) begin
                  cmd_d   = 3'b000;
                  wren_d  = 1'b1;
                  wdata_d = {4{bus.i_wdata}};
                  mask_d  = ~(16'h000F << {bus.i_addr[2:1], 2'b00});
                  state_d = WRITE;
               end else begin
                  cmd_d   = 3'b001;
                  state_d = READ_CMD;
               end
            end
         end
         WRITE: begin
            // Command and data handshakes retire independently; finish when both have.
            if (en_q && bus.i_app_rdy)       en_d   = 1'b0;
            if (wren_q && bus.i_app_wdf_rdy) wren_d = 1'b0;
            if (!en_d && !wren_d) begin
               kind_d  = K_DONE;
               state_d = RESP;
            end
         end
         READ_CMD: begin
            if (bus.i_app_rdy) begin
               en_d    = 1'b0;
               cnt_d   = '0;
               state_d = READ_WAIT;
            end
         end
         READ_WAIT: begin
            if (bus.i_app_rd_data_valid) begin
               rdata_d = bus.i_app_rd_data[{lane_q, 5'b00000} +: 32];
               kind_d  = K_RD;
               state_d = RESP;
            end else if (cnt_q == LAST) begin
               kind_d  = K_ERR;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign bus.o_ready        = (state_q == IDLE) && bus.i_calib;
   assign bus.o_done         = (state_q == RESP) && (kind_q == K_DONE);
   assign bus.o_rvalid       = (state_q == RESP) && (kind_q == K_RD);
   assign bus.o_err          = (state_q == RESP) && (kind_q == K_ERR);
   assign bus.o_rdata        = rdata_q;
   assign bus.o_app_addr     = addr_q;
   assign bus.o_app_cmd      = cmd_q;
   assign bus.o_app_en       = en_q;
   assign bus.o_app_wdf_data = wdata_q;
   assign bus.o_app_wdf_wren = wren_q;
   assign bus.o_app_wdf_end  = wren_q;
   assign bus.o_app_wdf_mask = mask_q;

endmodule

// File: tb/tb_m_dram_port.sv
// Directed self-checking bench for m_dram_port with a 16-cycle read watchdog.
module tb_m_dram_port;

   logic w_clk;
   logic w_rst;
   int   errors;
   int   checks;

   m_dram_port_if bus ();

   m_dram_port #(.TIMEOUT(16)) dut (
      .w_clk (w_clk),
      .w_rst (w_rst),
      .bus   (bus)
   );

   initial w_clk = 1'b0;
   always #5 w_clk = ~w_clk;

   task automatic tick();
      @(posedge w_clk);
      #1;
   endtask

   task automatic test_reset();
      #3;
      checks++; if (bus.o_app_en !== 1'b0) begin errors++; $display("FAIL rst_en got %b exp 0", bus.o_app_en); end
      checks++; if (bus.o_app_wdf_wren !== 1'b0) begin errors++; $display("FAIL rst_wren got %b exp 0", bus.o_app_wdf_wren); end
      checks++; if (bus.o_app_wdf_mask !== 16'hFFFF) begin errors++; $display("FAIL rst_mask got %h exp ffff", bus.o_app_wdf_mask); end
      checks++; if (bus.o_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", bus.o_rdata); end
      checks++; if ({bus.o_done, bus.o_rvalid, bus.o_err} !== 3'b000) begin errors++; $display("FAIL rst_pulses got %b exp 000", {bus.o_done, bus.o_rvalid, bus.o_err}); end
      checks++; if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", bus.o_ready); end
      @(posedge w_clk); #1;
      w_rst = 1'b0;
   endtask

   task automatic test_write_basic();
      bus.i_app_rdy = 1'b1; bus.i_app_wdf_rdy = 1'b1;
      bus.i_valid = 1'b1; bus.i_we = 1'b1; bus.i_addr = 28'h0000010; bus.i_wdata = 32'hA5A5_0001;
      #1;
      checks++; if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL wr_ready_pre got %b exp 1", bus.o_ready); end
      tick();
      bus.i_valid = 1'b0;
      checks++; if (bus.o_app_en !== 1'b1) begin errors++; $display("FAIL wr_en got %b exp 1", bus.o_app_en); end
      checks++; if (bus.o_app_wdf_wren !== 1'b1) begin errors++; $display("FAIL wr_wren got %b exp 1", bus.o_app_wdf_wren); end
      checks++; if (bus.o_app_wdf_end !== 1'b1) begin errors++; $display("FAIL wr_end got %b exp 1", bus.o_app_wdf_end); end
      checks++; if (bus.o_app_addr !== 28'h0000010) begin errors++; $display("FAIL wr_addr got %h exp 0000010", bus.o_app_addr); end
      checks++; if (bus.o_app_cmd !== 3'b000) begin errors++; $display("FAIL wr_cmd got %b exp 000", bus.o_app_cmd); end
      checks++; if (bus.o_app_wdf_mask !== 16'hFFF0) begin errors++; $display("FAIL wr_mask got %h exp fff0", bus.o_app_wdf_mask); end
      checks++; if (bus.o_app_wdf_data !== 128'hA5A50001_A5A50001_A5A50001_A5A50001) begin errors++; $display("FAIL wr_data got %h", bus.o_app_wdf_data); end
      checks++; if (bus.o_done !== 1'b0) begin errors++; $display("FAIL wr_done_early got %b exp 0", bus.o_done); end
      tick();
      checks++; if ({bus.o_app_en, bus.o_app_wdf_wren} !== 2'b00) begin errors++; $display("FAIL wr_drop got %b exp 00", {bus.o_app_en, bus.o_app_wdf_wren}); end
      checks++; if (bus.o_done !== 1'b1) begin errors++; $display("FAIL wr_done got %b exp 1", bus.o_done); end
      checks++; if (bus.o_ready !== 1'b0) begin errors++; $display("FAIL wr_ready_in_done got %b exp 0", bus.o_ready); end
      tick();
      checks++; if (bus.o_done !== 1'b0) begin errors++; $display("FAIL wr_done_width got %b exp 0", bus.o_done); end
      checks++; if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL wr_ready_post got %b exp 1", bus.o_ready); end
   endtask

   task automatic test_write_delayed();
      int en_cnt = 0, wren_cnt = 0, done_cnt = 0, done_cyc = 0;
      bus.i_app_rdy = 1'b0; bus.i_app_wdf_rdy = 1'b0;
      bus.i_valid = 1'b1; bus.i_we = 1'b1; bus.i_addr = 28'h0000006; bus.i_wdata = 32'h1234_5678;
      tick();
      bus.i_valid = 1'b0;
      checks++; if (bus.o_app_wdf_mask !== 16'h0FFF) begin errors++; $display("FAIL wd_mask got %h exp 0fff", bus.o_app_wdf_mask); end
      checks++; if (bus.o_app_addr !== 28'h0) begin errors++; $display("FAIL wd_addr got %h exp 0", bus.o_app_addr); end
      for (int c = 1; c <= 12; c++) begin
         if (bus.o_app_en) en_cnt++;
         if (bus.o_app_wdf_wren) wren_cnt++;
         if (bus.o_done) begin done_cnt++; done_cyc = c; end
         bus.i_app_rdy = (c >= 4);
         bus.i_app_wdf_rdy = (c >= 6);
         tick();
      end
      checks++; if (en_cnt !== 4) begin errors++; $display("FAIL wd_en_cycles got %0d exp 4", en_cnt); end
      checks++; if (wren_cnt !== 6) begin errors++; $display("FAIL wd_wren_cycles got %0d exp 6", wren_cnt); end
      checks++; if (done_cnt !== 1) begin errors++; $display("FAIL wd_done_count got %0d exp 1", done_cnt); end
      checks++; if (done_cyc !== 7) begin errors++; $display("FAIL wd_done_cycle got %0d exp 7", done_cyc); end
      bus.i_app_rdy = 1'b1; bus.i_app_wdf_rdy = 1'b1;
   endtask

   task automatic test_read();
      int en_cnt = 0, rv_cnt = 0, rv_cyc = 0, other = 0;
      bus.i_app_rd_data = {32'h4, 32'h3, 32'h2, 32'h1};
      bus.i_valid = 1'b1; bus.i_we = 1'b0; bus.i_addr = 28'h000000C;
      tick();
      bus.i_valid = 1'b0;
      checks++; if (bus.o_app_cmd !== 3'b001) begin errors++; $display("FAIL rd_cmd got %b exp 001", bus.o_app_cmd); end
      checks++; if (bus.o_app_addr !== 28'h0000008) begin errors++; $display("FAIL rd_addr got %h exp 0000008", bus.o_app_addr); end
      for (int c = 1; c <= 14; c++) begin
         if (bus.o_app_en) en_cnt++;
         if (bus.o_app_wdf_wren || bus.o_done || bus.o_err) other++;
         if (bus.o_rvalid) begin rv_cnt++; rv_cyc = c; end
         bus.i_app_rd_data_valid = (c == 7);
         tick();
      end
      checks++; if (en_cnt !== 1) begin errors++; $display("FAIL rd_en_cycles got %0d exp 1", en_cnt); end
      checks++; if (other !== 0) begin errors++; $display("FAIL rd_stray_outputs got %0d exp 0", other); end
      checks++; if (rv_cnt !== 1) begin errors++; $display("FAIL rd_rvalid_count got %0d exp 1", rv_cnt); end
      checks++; if (rv_cyc !== 8) begin errors++; $display("FAIL rd_rvalid_cycle got %0d exp 8", rv_cyc); end
      checks++; if (bus.o_rdata !== 32'h3) begin errors++; $display("FAIL rd_rdata got %h exp 00000003", bus.o_rdata); end
   endtask

   task automatic test_timeout();
      int err_cnt = 0, err_cyc = 0, rv_cnt = 0;
      logic rdy19 = 1'b0;
      bus.i_app_rd_data = {4{32'hDEAD_BEEF}};
      bus.i_valid = 1'b1; bus.i_we = 1'b0; bus.i_addr = 28'h0;
      tick();
      bus.i_valid = 1'b0;
      for (int c = 1; c <= 25; c++) begin
         if (bus.o_err) begin err_cnt++; if (err_cyc == 0) err_cyc = c; end
         if (bus.o_rvalid) rv_cnt++;
         if (c == 19) rdy19 = bus.o_ready;
         bus.i_app_rd_data_valid = (c == 21);
         tick();
      end
      checks++; if (err_cyc !== 18) begin errors++; $display("FAIL to_err_cycle got %0d exp 18", err_cyc); end
      checks++; if (err_cnt !== 1) begin errors++; $display("FAIL to_err_count got %0d exp 1", err_cnt); end
      checks++; if (rdy19 !== 1'b1) begin errors++; $display("FAIL to_ready_after got %b exp 1", rdy19); end
      checks++; if (rv_cnt !== 0) begin errors++; $display("FAIL to_rvalid_count got %0d exp 0", rv_cnt); end
      checks++; if (bus.o_rdata !== 32'h3) begin errors++; $display("FAIL to_rdata_hold got %h exp 00000003", bus.o_rdata); end
   endtask

   task automatic test_calib();
      int bad = 0;
      bus.i_calib = 1'b0;
      bus.i_valid = 1'b1; bus.i_we = 1'b0; bus.i_addr = 28'h0;
      bus.i_app_rd_data = {32'h4, 32'h3, 32'h2, 32'h1};
      for (int c = 0; c < 4; c++) begin
         #1;
         if (bus.o_ready || bus.o_app_en) bad++;
         tick();
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL cal_blocked got %0d exp 0", bad); end
      bus.i_calib = 1'b1;
      #1;
      checks++; if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL cal_ready got %b exp 1", bus.o_ready); end
      tick();
      bus.i_valid = 1'b0;
      checks++; if (bus.o_app_en !== 1'b1) begin errors++; $display("FAIL cal_accept got %b exp 1", bus.o_app_en); end
      bus.i_calib = 1'b0;
      tick();
      bus.i_app_rd_data_valid = 1'b1;
      tick();
      bus.i_app_rd_data_valid = 1'b0;
      checks++; if (bus.o_rvalid !== 1'b1) begin errors++; $display("FAIL cal_drop_rvalid got %b exp 1", bus.o_rvalid); end
      checks++; if (bus.o_rdata !== 32'h1) begin errors++; $display("FAIL cal_drop_rdata got %h exp 00000001", bus.o_rdata); end
      bus.i_calib = 1'b1;
      tick();
   endtask

   task automatic test_reset_mid();
      int pulses = 0;
      bus.i_valid = 1'b1; bus.i_we = 1'b0; bus.i_addr = 28'h0000004;
      tick();
      bus.i_valid = 1'b0;
      tick();
      tick();
      #2 w_rst = 1'b1;
      #1;
      checks++; if (bus.o_app_en !== 1'b0) begin errors++; $display("FAIL rm_en got %b exp 0", bus.o_app_en); end
      checks++; if (bus.o_app_addr !== 28'h0 || bus.o_app_cmd !== 3'b000) begin errors++; $display("FAIL rm_addr_cmd got %h/%b exp 0/000", bus.o_app_addr, bus.o_app_cmd); end
      checks++; if (bus.o_app_wdf_data !== 128'h0) begin errors++; $display("FAIL rm_wdata got %h exp 0", bus.o_app_wdf_data); end
      checks++; if (bus.o_app_wdf_mask !== 16'hFFFF) begin errors++; $display("FAIL rm_mask got %h exp ffff", bus.o_app_wdf_mask); end
      checks++; if (bus.o_rdata !== 32'h0) begin errors++; $display("FAIL rm_rdata got %h exp 0", bus.o_rdata); end
      checks++; if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL rm_ready got %b exp 1", bus.o_ready); end
      @(posedge w_clk); #1;
      w_rst = 1'b0;
      bus.i_app_rd_data_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         if (bus.o_rvalid || bus.o_err || bus.o_done) pulses++;
         tick();
      end
      bus.i_app_rd_data_valid = 1'b0;
      checks++; if (pulses !== 0) begin errors++; $display("FAIL rm_no_pulse got %0d exp 0", pulses); end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      w_rst = 1'b1;
      bus.i_calib = 1'b1;
      bus.i_valid = 1'b0;
      bus.i_we = 1'b0;
      bus.i_addr = '0;
      bus.i_wdata = '0;
      bus.i_app_rd_data = '0;
      bus.i_app_rd_data_valid = 1'b0;
      bus.i_app_rdy = 1'b0;
      bus.i_app_wdf_rdy = 1'b0;
      test_reset();
      test_write_basic();
      test_write_delayed();
      test_read();
      test_timeout();
      test_calib();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
